// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - test-pattern sequencer with serial ramp-step divider
module pattern_sequencer #(
  parameter int B               = 8,
  parameter int X_BITS          = 12,
  parameter int FRACTIONAL_BITS = 12,
  parameter int DWELL_BITS      = 8
) (
  input  logic                         clk_in,
  input  logic                         reset_n,
  input  logic                         vn_in,
  input  logic [X_BITS-1:0]            total_active_pix,
  input  logic                         auto_en,
  input  logic [7:0]                   manual_pattern,
  input  logic [DWELL_BITS-1:0]        dwell_frames,
  output logic [7:0]                   pattern,
  output logic [B+FRACTIONAL_BITS-1:0] ramp_step,
  output logic                         step_valid,
  output logic                         busy,
  output logic [DWELL_BITS-1:0]        frame_cnt
);

  localparam int W  = B + FRACTIONAL_BITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [X_BITS-1:0]       divisor_q, divisor_d;
  logic [X_BITS-1:0]       rem_q, rem_d;
  logic [W:0]              quot_q, quot_d;
  logic [W-1:0]            step_next_q, step_next_d;
  logic                    pending_q, pending_d;
  logic                    first_q;
  logic                    vn_d_q;
  logic [7:0]              pattern_q, pattern_d;
  logic [DWELL_BITS-1:0]   frame_cnt_q, frame_cnt_d;
  logic [W-1:0]            ramp_q, ramp_d;
  logic                    valid_q, valid_d;

  logic                    frame_start;
  logic                    div_change;
  logic                    start_div;
  logic [X_BITS:0]         rem_shift;
  logic [X_BITS-1:0]       rem_sub;
  logic                    rem_ge;
  logic [DWELL_BITS-1:0]   dwell_last;

  // The first cycle after reset release never counts as a frame start, so a
  // low vn_in at release is not mistaken for a falling edge.
  assign frame_start = ~first_q & vn_d_q & ~vn_in;
  assign div_change  = (total_active_pix != divisor_q);
  assign start_div   = ((state_q == S_IDLE) && (first_q || div_change)) ||
                       ((state_q == S_DIV) && div_change);

  // Dividend is 2^W: its only set bit enters the remainder on the first step.
  assign rem_shift = {rem_q, (cnt_q == '0)};
  assign rem_ge    = (rem_shift >= {1'b0, divisor_q});
  assign rem_sub   = rem_shift[X_BITS-1:0] - divisor_q;
  assign dwell_last = (dwell_frames == '0) ? '0 : dwell_frames - DWELL_BITS'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    step_next_d = step_next_q;
    pending_d   = pending_q;
    pattern_d   = pattern_q;
    frame_cnt_d = frame_cnt_q;
    ramp_d      = ramp_q;
    valid_d     = valid_q;

    if (frame_start) begin
      if (pending_q) begin
        ramp_d  = step_next_q;
        valid_d = 1'b1;
      end
      pending_d = 1'b0;
      if (!auto_en) begin
        pattern_d   = manual_pattern;
        frame_cnt_d = '0;
      end else if ((pattern_q == 8'd0) || (pattern_q > 8'd4)) begin
        pattern_d   = 8'd1;
        frame_cnt_d = '0;
      end else if (frame_cnt_q >= dwell_last) begin
        pattern_d   = (pattern_q == 8'd4) ? 8'd1 : pattern_q + 8'd1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + DWELL_BITS'(1);
      end
    end

    if (start_div) begin
      divisor_d = total_active_pix;
      rem_d     = '0;
      cnt_d     = '0;
      if (total_active_pix == '0) begin
        quot_d  = '1;
        state_d = S_DONE;
      end else begin
        quot_d  = '0;
        state_d = S_DIV;
      end
    end else begin
      case (state_q)
        S_DIV: begin
          rem_d  = rem_ge ? rem_sub : rem_shift[X_BITS-1:0];
          quot_d = {quot_q[W-1:0], rem_ge};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(W)) state_d = S_DONE;
        end
        S_DONE: begin
          // A result that reaches 2^W (divisor 1) saturates.
          step_next_d = quot_q[W] ? '1 : quot_q[W-1:0];
          pending_d   = 1'b1;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      step_next_q <= '0;
      pending_q   <= 1'b0;
      first_q     <= 1'b1;
      vn_d_q      <= 1'b1;
      pattern_q   <= '0;
      frame_cnt_q <= '0;
      ramp_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      step_next_q <= step_next_d;
      pending_q   <= pending_d;
      first_q     <= 1'b0;
      vn_d_q      <= vn_in;
      pattern_q   <= pattern_d;
      frame_cnt_q <= frame_cnt_d;
      ramp_q      <= ramp_d;
      valid_q     <= valid_d;
    end
  end

  assign pattern    = pattern_q;
  assign ramp_step  = ramp_q;
  assign step_valid = valid_q;
  assign busy       = (state_q == S_DIV);
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed scoreboard bench for pattern_sequencer
module tb_pattern_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        vn_in = 1'b1;
  logic [11:0] total_active_pix = 12'd1280;
  logic        auto_en = 1'b0;
  logic [7:0]  manual_pattern = 8'd0;
  logic [7:0]  dwell_frames = 8'd2;
  logic [7:0]  pattern;
  logic [19:0] ramp_step;
  logic        step_valid;
  logic        busy;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  pat;
    logic [7:0]  cnt;
    logic [19:0] ramp;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  pattern_sequencer dut (
    .clk_in(clk_in), .reset_n(reset_n), .vn_in(vn_in),
    .total_active_pix(total_active_pix), .auto_en(auto_en),
    .manual_pattern(manual_pattern), .dwell_frames(dwell_frames),
    .pattern(pattern), .ramp_step(ramp_step), .step_valid(step_valid),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] p, input logic [7:0] c,
                       input logic [19:0] r, input logic v);
    exp_t e;
    sb.push_back('{pat: p, cnt: c, ramp: r, valid: v});
    @(posedge clk_in); #1 vn_in = 1'b0;
    @(posedge clk_in); #1;
    e = sb.pop_front();
    chk({tag, "_pattern"},   32'(pattern),    32'(e.pat));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt),  32'(e.cnt));
    chk({tag, "_ramp"},      32'(ramp_step),  32'(e.ramp));
    chk({tag, "_valid"},     32'(step_valid), 32'(e.valid));
    repeat (3) @(posedge clk_in);
    #1 vn_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (2) @(posedge clk_in);
    #1;
    while (busy && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk({tag, "_div_timeout"}, 32'(busy), 32'd0);
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  initial begin
    int nbusy;

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_pattern",   32'(pattern),    32'd0);
    chk("rst_ramp",      32'(ramp_step),  32'd0);
    chk("rst_valid",     32'(step_valid), 32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt),  32'd0);

    reset_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in); #1;
      if (busy) nbusy++;
    end
    chk("busy_cycles_1280", 32'(nbusy), 32'd21);
    chk("ramp_held_before_frame", 32'(ramp_step), 32'd0);
    chk("valid_held_before_frame", 32'(step_valid), 32'd0);
    frame("first_frame", 8'd0, 8'd0, 20'd819, 1'b1);

    auto_en = 1'b1;
    dwell_frames = 8'd2;
    for (int i = 0; i < 10; i++)
      frame($sformatf("auto_d2_%0d", i), 8'((i / 2) % 4 + 1), 8'(i % 2), 20'd819, 1'b1);

    dwell_frames = 8'd0;
    for (int i = 0; i < 5; i++)
      frame($sformatf("auto_d0_%0d", i), 8'((i + 1) % 4 + 1), 8'd0, 20'd819, 1'b1);

    reset_n = 1'b0;
    #1;
    chk("midrst_pattern",   32'(pattern),    32'd0);
    chk("midrst_ramp",      32'(ramp_step),  32'd0);
    chk("midrst_valid",     32'(step_valid), 32'd0);
    chk("midrst_busy",      32'(busy),       32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt),  32'd0);
    auto_en = 1'b0;
    manual_pattern = 8'd5;
    vn_in = 1'b0;
    total_active_pix = 12'd1280;
    repeat (2) @(posedge clk_in);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("vn_low_at_release_pattern", 32'(pattern), 32'd0);
    chk("busy_after_release", 32'(busy), 32'd1);
    vn_in = 1'b1;
    repeat (7) @(posedge clk_in);
    #1 total_active_pix = 12'd1920;
    repeat (15) @(posedge clk_in);
    #1;
    frame("abort_no_stale", 8'd5, 8'd0, 20'd0, 1'b0);
    wait_idle("abort");
    frame("abort_1920", 8'd5, 8'd0, 20'd546, 1'b1);

    manual_pattern = 8'd3;
    repeat (5) @(posedge clk_in);
    #1;
    chk("manual_midframe_hold", 32'(pattern), 32'd5);
    frame("manual_3", 8'd3, 8'd0, 20'd546, 1'b1);

    total_active_pix = 12'd2;
    wait_idle("div2");
    frame("div2", 8'd3, 8'd0, 20'h80000, 1'b1);
    total_active_pix = 12'd1;
    wait_idle("div1");
    frame("div1_sat", 8'd3, 8'd0, 20'hFFFFF, 1'b1);
    total_active_pix = 12'd2;
    wait_idle("div2b");
    frame("div2b", 8'd3, 8'd0, 20'h80000, 1'b1);

    total_active_pix = 12'd0;
    nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_in); #1;
      if (busy) nbusy++;
    end
    chk("div0_busy_cycles", 32'(nbusy), 32'd0);
    frame("div0_sat", 8'd3, 8'd0, 20'hFFFFF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter B, default 8, bits per colour channel.
REQ-002 Parameter X_BITS, default 12, width of total_active_pix.
REQ-003 Parameter FRACTIONAL_BITS, default 12, fractional bits of ramp_step.
REQ-004 Parameter DWELL_BITS, default 8, width of dwell_frames and frame_cnt.
REQ-005 clk_in  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset; release is synchronous to clk_in.
REQ-007 vn_in  input  1  active-low vertical sync from the timing generator.
REQ-008 total_active_pix  input  X_BITS  active pixels per line.
REQ-009 auto_en  input  1  1 = cycle patterns automatically; 0 = manual selection.
REQ-010 manual_pattern  input  8  pattern code applied when auto_en=0.
REQ-011 dwell_frames  input  DWELL_BITS  frames spent on each pattern in auto mode.
REQ-012 pattern  output  8  pattern code for the pattern generator.
REQ-013 ramp_step  output  B+FRACTIONAL_BITS  ramp increment for the pattern generator.
REQ-014 step_valid  output  1  ramp_step holds a computed value.
REQ-015 busy  output  1  divider is running.
REQ-016 frame_cnt  output  DWELL_BITS  frames elapsed on the current auto pattern.

Function
REQ-017 Frame start SHALL be a falling edge of vn_in, detected from a one-cycle delayed copy (vn_d, reset value 1); it SHALL act one cycle after the edge.
REQ-018 The divider SHALL compute ramp_step_next = floor(2^(B+FRACTIONAL_BITS) / total_active_pix) as a restoring serial divider, one quotient bit per cycle.
REQ-019 Divider FSM states: IDLE, DIV, DONE; busy=1 exactly in DIV.
REQ-020 IDLE->DIV when total_active_pix differs from the latched divisor, or on the first cycle after reset release; divisor latched on this transition.
REQ-021 DIV SHALL last B+FRACTIONAL_BITS+1 cycles, then go to DONE; DONE stores the result to step_next, sets a pending flag and returns to IDLE (1 cycle).
REQ-022 total_active_pix changing during DIV SHALL abort and restart DIV with the new divisor; the stale result SHALL NOT be stored.
REQ-023 Quotient overflow (divisor 1) SHALL saturate to all ones; divisor 0 SHALL give all ones without running DIV.
REQ-024 At a frame start with pending set: ramp_step <= step_next, step_valid <= 1, pending cleared; ramp_step SHALL NOT change at any other time.
REQ-025 Auto mode, at frame start: if frame_cnt >= max(dwell_frames,1)-1, frame_cnt <= 0 and pattern advances 1->2->3->4->1; else frame_cnt increments.
REQ-026 Entering auto mode from pattern 0 or any code >4 SHALL load pattern 1 at the next frame start, with frame_cnt cleared.
REQ-027 Manual mode, at frame start: pattern <= manual_pattern, frame_cnt <= 0.
REQ-028 Changes to auto_en, manual_pattern or dwell_frames SHALL take effect only at a frame start.
REQ-029 When a frame start and a DONE fall on the same cycle, the new result SHALL wait for the next frame start.

Reset
REQ-030 While reset_n=0: pattern=0, ramp_step=0, step_valid=0, busy=0, frame_cnt=0, FSM=IDLE, pending=0, vn_d=1.
REQ-031 Reset asserted mid-division SHALL abandon the division; a fresh division SHALL start after release.
REQ-032 vn_in already low at reset release SHALL NOT produce a frame start.

Verification
REQ-033 total_active_pix=1280, release reset -> busy high 21 cycles; after next vn_in fall ramp_step=819 (0x333), step_valid=1.
REQ-034 auto_en=1, dwell_frames=2, 10 frames -> pattern sequence 1,1,2,2,3,3,4,4,1,1; frame_cnt alternates 0/1.
REQ-035 dwell_frames=0 -> pattern advances every frame.
REQ-036 Change pix 1280->1920 at DIV cycle 10 -> division restarts, no 819 committed; ramp_step=546 after next frame start.
REQ-037 total_active_pix=1 and 0 -> ramp_step=0xFFFFF both cases; busy stays 0 for divisor 0.
REQ-038 auto_en=0, manual_pattern=3 changed mid-frame -> pattern updates only one cycle after the next vn_in fall; reset pulse mid-frame -> all outputs 0 immediately.
